// File: rtl/tt_harness_pkg.sv
// Shared definitions for the stimulus/capture harness.
//   state_e    : run-control FSM states
//   MODE_*     : stimulus pattern encodings carried on the `mode` port
//   lfsr_step  : one Galois shift-right step; the pattern generator and
//                the MISR both use it. Callers pass zero-extended operands
//                and keep the low WIDTH bits of the result.
package tt_harness_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [1:0] MODE_COUNT = 2'd0;
  localparam logic [1:0] MODE_LFSR  = 2'd1;
  localparam logic [1:0] MODE_WALK  = 2'd2;
  localparam logic [1:0] MODE_HOLD  = 2'd3;

  function automatic logic [31:0] lfsr_step(input logic [31:0] value,
                                            input logic [31:0] taps);
    logic [31:0] shifted;
    shifted = value >> 1;
    if (value[0]) shifted = shifted ^ taps;
    return shifted;
  endfunction

endpackage

// File: rtl/tt_capture_fifo.sv
// Synchronous capture FIFO with first-word fall-through.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   flush        : empties the FIFO (wins over push/pop)
//   push, wdata  : write one word; accepted when not full, or when full and
//                  a pop is accepted in the same cycle
//   pop          : remove the head word; ignored when empty
//   rdata        : head word (0 when empty)
//   full, empty  : status
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module tt_capture_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic             do_push, do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rptr_d = rptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/tt_stim_capture.sv
// Stimulus/capture harness: drives a pattern into a user DUT, captures the
// response LAT cycles later into a FIFO and folds it into a MISR.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : launch a run (only in IDLE or DONE)
//   mode, seed, len   : pattern select, first word, word count (0 = 256)
//   stim              : stimulus to the DUT
//   resp              : DUT response
//   rd_en, rd_data,
//   rd_valid          : capture buffer read port
//   overflow          : sticky, a capture found the buffer full
//   signature         : MISR value, final once done = 1
//   busy, done        : run in progress / run complete
//   dbg_state         : current FSM state
// Read handshake: a word is consumed on a clock edge where rd_en and
// rd_valid are both high; rd_data is the head word while rd_valid is high.
module tt_stim_capture import tt_harness_pkg::*; #(
  parameter int          WIDTH     = 8,
  parameter int          DEPTH     = 16,
  parameter int          LAT       = 1,
  parameter logic [31:0] LFSR_TAPS = 32'h0000_00B8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] seed,
  input  logic [7:0]       len,
  output logic [WIDTH-1:0] stim,
  input  logic [WIDTH-1:0] resp,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             overflow,
  output logic [WIDTH-1:0] signature,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  localparam int               DL   = (LAT == 0) ? 1 : LAT;
  localparam logic [WIDTH-1:0] TAPS = LFSR_TAPS[WIDTH-1:0];

  state_e           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [8:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] stim_q, stim_d;
  logic [WIDTH-1:0] sig_q, sig_d;
  logic             ovf_q, ovf_d;
  logic [DL-1:0]    vld_q;

  logic             issue, cap, flush;
  logic             fifo_full, fifo_empty;
  logic [WIDTH-1:0] seed_eff, stim_next, misr_next;

  // LFSR and walking-one cannot leave an all-zero state, so substitute 1.
  assign seed_eff = (((mode == MODE_LFSR) || (mode == MODE_WALK)) && (seed == '0))
                    ? WIDTH'(1) : seed;

  always_comb begin
    stim_next = stim_q;
    case (mode_q)
      MODE_COUNT: stim_next = stim_q + WIDTH'(1);
      MODE_LFSR:  stim_next = WIDTH'(lfsr_step(32'(stim_q), 32'(TAPS)));
      MODE_WALK:  stim_next = {stim_q[WIDTH-2:0], stim_q[WIDTH-1]};
      default:    stim_next = stim_q;
    endcase
  end

  assign misr_next = WIDTH'(lfsr_step(32'(sig_q), 32'(TAPS))) ^ resp;

  // Every RUN cycle drives one word; its response is valid LAT cycles on.
  assign issue = (state_q == ST_RUN);
  assign cap   = (LAT == 0) ? issue : vld_q[DL-1];

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    stim_d  = stim_q;
    sig_d   = sig_q;
    ovf_d   = ovf_q;
    flush   = 1'b0;

    if (cap) begin
      sig_d = misr_next;
      // A pop in the same cycle frees a slot, so a full buffer only drops
      // the word when nothing is read.
      if (fifo_full && !rd_en) ovf_d = 1'b1;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          mode_d  = mode;
          stim_d  = seed_eff;
          cnt_d   = (len == 8'd0) ? 9'd256 : {1'b0, len};
          sig_d   = '0;
          ovf_d   = 1'b0;
          flush   = 1'b1;
        end
      end
      ST_RUN: begin
        // cnt_q counts words still to be driven, including the current one.
        if (cnt_q == 9'd1) begin
          if (LAT == 0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_DRAIN;
            cnt_d   = 9'(LAT);
          end
        end else begin
          cnt_d  = cnt_q - 9'd1;
          stim_d = stim_next;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == 9'd1) state_d = ST_DONE;
        else               cnt_d   = cnt_q - 9'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_COUNT;
      cnt_q   <= '0;
      stim_q  <= '0;
      sig_q   <= '0;
      ovf_q   <= 1'b0;
      vld_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      stim_q  <= stim_d;
      sig_q   <= sig_d;
      ovf_q   <= ovf_d;
      vld_q   <= DL'({vld_q, issue});
    end
  end

  tt_capture_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (cap),
    .wdata (resp),
    .pop   (rd_en),
    .rdata (rd_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign stim      = stim_q;
  assign signature = sig_q;
  assign overflow  = ovf_q;
  assign rd_valid  = !fifo_empty;
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_tt_stim_capture.sv
// Bench for tt_stim_capture (WIDTH 8, DEPTH 16, LAT 1) with a registered
// identity DUT of one-cycle latency between stim and resp.
module tb_tt_stim_capture;
  import tt_harness_pkg::*;

  localparam int         WIDTH = 8;
  localparam int         DEPTH = 16;
  localparam int         LAT   = 1;
  localparam logic [7:0] TAPS  = 8'hB8;

  logic             clk = 1'b0;
  logic             rst, start, rd_en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] seed;
  logic [7:0]       len;
  logic [WIDTH-1:0] stim, resp, rd_data, signature;
  logic             rd_valid, overflow, busy, done;
  logic [1:0]       dbg_state;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_q[$];

  typedef struct {
    logic [1:0] mode;
    logic [7:0] seed;
    logic [7:0] len;
    logic [7:0] w0;
    logic [7:0] w1;
    bit         ovf;
    bit         do_pop;
    int         inject_at;
  } vec_t;

  vec_t vecs[9];

  // ---------------- clock / reset / DUT ----------------
  always #5 clk = ~clk;

  logic [WIDTH-1:0] user_q;
  always_ff @(posedge clk) user_q <= stim;
  assign resp = user_q;

  tt_stim_capture #(
    .WIDTH (WIDTH), .DEPTH (DEPTH), .LAT (LAT), .LFSR_TAPS (32'h0000_00B8)
  ) dut (
    .clk (clk), .rst (rst), .start (start), .mode (mode), .seed (seed),
    .len (len), .stim (stim), .resp (resp), .rd_en (rd_en),
    .rd_data (rd_data), .rd_valid (rd_valid), .overflow (overflow),
    .signature (signature), .busy (busy), .done (done),
    .dbg_state (dbg_state)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] m_step(input logic [7:0] v);
    return v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
  endfunction

  // k-th stimulus word of a run, derived directly from the pattern rules.
  function automatic logic [7:0] m_word(input logic [1:0] m, input logic [7:0] s,
                                        input int k);
    logic [7:0] v;
    int r;
    v = s;
    case (m)
      MODE_COUNT: v = s + 8'(k);
      MODE_LFSR: begin
        if (s == 8'd0) v = 8'd1;
        for (int i = 0; i < k; i++) v = m_step(v);
      end
      MODE_WALK: begin
        if (s == 8'd0) v = 8'd1;
        r = k % 8;
        v = (v << r) | (v >> (8 - r));
      end
      default: v = s;
    endcase
    return v;
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic pop_all(input string tag);
    int bad, i;
    logic [7:0] a, e;
    bad = 0; i = 0; a = 0; e = 0;
    while (exp_q.size() > 0) begin
      logic [7:0] w;
      w = exp_q.pop_front();
      if (rd_valid !== 1'b1 || rd_data !== w) begin
        if (bad == 0) begin a = rd_data; e = w; end
        bad++;
      end
      rd_en = 1'b1;
      @(negedge clk);
      i++;
    end
    rd_en = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_pop_seq bad=%0d first actual=%0h required=%0h", tag, bad, a, e);
    end
    check({tag, "_rd_empty"}, rd_valid, 0);
  endtask

  // ---------------- driver: one complete run ----------------
  task automatic run_vec(input vec_t v, input string tag);
    int n, bad;
    logic [7:0] w, a, e, msig;
    bit movf;
    n = (v.len == 8'd0) ? 256 : int'(v.len);
    exp_q.delete();
    msig = 8'd0;
    for (int k = 0; k < n; k++) begin
      w = m_word(v.mode, v.seed, k);
      msig = m_step(msig) ^ w;
      if (exp_q.size() < DEPTH) exp_q.push_back(w);
    end
    movf = (n > DEPTH);

    @(negedge clk);
    start = 1'b1; mode = v.mode; seed = v.seed; len = v.len;
    @(negedge clk);
    start = 1'b0; mode = 2'($urandom); seed = 8'($urandom); len = 8'($urandom);
    check({tag, "_busy_rise"}, busy, 1);
    check({tag, "_sig_clr"}, signature, 0);
    check({tag, "_ovf_clr"}, overflow, 0);
    check({tag, "_flushed"}, rd_valid, 0);

    bad = 0; a = 0; e = 0;
    for (int k = 0; k < n; k++) begin
      if (k == 0) check({tag, "_w0"}, stim, v.w0);
      if (k == 1) check({tag, "_w1"}, stim, v.w1);
      w = m_word(v.mode, v.seed, k);
      if (stim !== w || busy !== 1'b1 || done !== 1'b0) begin
        if (bad == 0) begin a = stim; e = w; end
        bad++;
      end
      if (k == v.inject_at) begin
        start = 1'b1; mode = MODE_HOLD; seed = 8'h99; len = 8'd2;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_stim_seq bad=%0d first actual=%0h required=%0h", tag, bad, a, e);
    end

    // Drain cycle: no new stimulus, last word held.
    check({tag, "_drain_busy"}, busy, 1);
    check({tag, "_drain_done"}, done, 0);
    check({tag, "_drain_hold"}, stim, m_word(v.mode, v.seed, n - 1));
    @(negedge clk);
    check({tag, "_done"}, done, 1);
    check({tag, "_busy_fall"}, busy, 0);
    check({tag, "_signature"}, signature, msig);
    check({tag, "_ovf_model"}, overflow, movf);
    check({tag, "_ovf_table"}, overflow, v.ovf);
    if (v.do_pop) pop_all(tag);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vec_t rv;
    rst = 1'b1; start = 1'b0; rd_en = 1'b0; mode = 2'd0; seed = 8'd0; len = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_stim", stim, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_overflow", overflow, 0);
    check("rst_signature", signature, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;

    //              mode        seed   len    w0     w1     ovf   pop   inject
    vecs[0] = '{MODE_COUNT, 8'h05, 8'd4,  8'h05, 8'h06, 1'b0, 1'b1, -1};
    vecs[1] = '{MODE_LFSR,  8'h00, 8'd6,  8'h01, 8'hB8, 1'b0, 1'b1, -1};
    vecs[2] = '{MODE_WALK,  8'h00, 8'd10, 8'h01, 8'h02, 1'b0, 1'b1, -1};
    vecs[3] = '{MODE_WALK,  8'h10, 8'd20, 8'h10, 8'h20, 1'b1, 1'b1, -1};
    vecs[4] = '{MODE_HOLD,  8'hA5, 8'd3,  8'hA5, 8'hA5, 1'b0, 1'b0, -1};
    vecs[5] = '{MODE_COUNT, 8'hFE, 8'd0,  8'hFE, 8'hFF, 1'b1, 1'b1, -1};
    vecs[6] = '{MODE_LFSR,  8'h5A, 8'd16, 8'h5A, 8'h2D, 1'b0, 1'b1, -1};
    vecs[7] = '{MODE_WALK,  8'h80, 8'd2,  8'h80, 8'h01, 1'b0, 1'b1, -1};
    vecs[8] = '{MODE_COUNT, 8'h10, 8'd8,  8'h10, 8'h11, 1'b0, 1'b1, 3};

    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Randomized runs against the model.
    for (int i = 0; i < 12; i++) begin
      rv.mode = 2'($urandom_range(0, 3));
      rv.seed = 8'($urandom_range(0, 255));
      rv.len  = 8'($urandom_range(2, 40));
      rv.w0   = m_word(rv.mode, rv.seed, 0);
      rv.w1   = m_word(rv.mode, rv.seed, 1);
      rv.ovf  = (int'(rv.len) > DEPTH);
      rv.do_pop = 1'b1;
      rv.inject_at = (i % 3 == 0) ? int'($urandom_range(0, 1)) : -1;
      run_vec(rv, $sformatf("rnd%0d", i));
    end

    // Push and pop together on a full buffer: both succeed, no overflow.
    @(negedge clk);
    start = 1'b1; mode = MODE_COUNT; seed = 8'h00; len = 8'd17;
    @(negedge clk);
    start = 1'b0;
    repeat (17) @(negedge clk);
    check("full_valid", rd_valid, 1);
    check("full_head", rd_data, 8'h00);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    check("pushpop_done", done, 1);
    check("pushpop_no_ovf", overflow, 0);
    exp_q.delete();
    for (int k = 1; k <= 16; k++) exp_q.push_back(8'(k));
    pop_all("pushpop");

    // Reset in the middle of a run.
    @(negedge clk);
    start = 1'b1; mode = MODE_LFSR; seed = 8'h33; len = 8'd30;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("midrun_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_stim", stim, 0);
    check("mrst_rd_data", rd_data, 0);
    check("mrst_rd_valid", rd_valid, 0);
    check("mrst_overflow", overflow, 0);
    check("mrst_signature", signature, 0);
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_idle_busy", busy, 0);
    check("post_rst_idle_valid", rd_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
